npc_redirect_ctrl: RTL and testbench
====================================

Name: npc_redirect_ctrl

Overview:
- Owns the fetch program counter of the pipelined miniRV core and sequences every PC update.
- Arbitrates between sequential fetch (pc+4), taken branch/jump redirects resolved in EX (npc_op/npc_change from the next-PC decision logic), and load-use stalls from the hazard unit.
- Generates the IF/ID and ID/EX flush strobes.
- Inserts fetch bubbles after reset and after each redirect to cover synchronous instruction-ROM read latency.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_CYCLES, 1, cycles after reset release with fetch_valid low (range 1..15).
- REDIRECT_BUBBLES, 1, cycles with fetch_valid low after a taken redirect (range 0..15).

Ports:
- cpu_clk, in, 1, core clock; all state updates on rising edge.
- cpu_rst, in, 1, synchronous active-high reset.
- stall_if, in, 1, load-use stall request: hold PC and IF/ID.
- ex_valid, in, 1, EX stage holds a real (non-bubble) instruction.
- npc_op, in, 1, EX redirect taken (branch taken, jal, jalr).
- npc_change, in, 32, redirect target.
- pc, out, 32, current fetch PC (registered).
- pc4, out, 32, pc + 4.
- fetch_valid, out, 1, instruction fetched at pc is valid to enter IF/ID.
- hold_pc, out, 1, PC held this cycle (stall).
- flush_ifid, out, 1, flush IF/ID at next edge.
- flush_idex, out, 1, flush ID/EX at next edge.
- misalign_err, out, 1, sticky: a taken target had npc_change[1:0] != 0.
- redirect_cnt, out, 32, taken-redirect count (see Optional Feature).
- stall_cnt, out, 32, stall-cycle count (see Optional Feature).

Behaviour:
- Reset (cpu_rst=1 at an edge): pc=RESET_PC, state=BOOT, bubble counter=BOOT_CYCLES-1, misalign_err=0.
- While cpu_rst=1, all combinational outputs are forced 0: fetch_valid, hold_pc, flush_ifid, flush_idex. Reset mid-operation discards any pending redirect or bubble count.
- States:
  - BOOT: pc holds RESET_PC, fetch_valid=0; npc_op and stall_if ignored. After BOOT_CYCLES edges -> RUN.
  - RUN: fetch_valid=1.
  - FLUSH: fetch_valid=0, pc holds the redirect target, stall_if ignored. After REDIRECT_BUBBLES edges -> RUN.
- take = ex_valid & npc_op & (state != BOOT), combinational.
- Priority per edge: take > stall_if > sequential.
- On take:
  - pc <= {npc_change[31:2], 2'b00}.
  - flush_ifid=1 and flush_idex=1 during the same cycle (combinational).
  - If REDIRECT_BUBBLES=0, stay/go RUN; else -> FLUSH with counter=REDIRECT_BUBBLES-1.
  - take during FLUSH restarts the counter and reloads pc.
  - If npc_change[1:0] != 0, set misalign_err (sticky until reset); the redirect still occurs.
- RUN with stall_if=1 and no take: hold_pc=1, pc unchanged, no flush. A simultaneous take overrides the stall (hold_pc=0).
- RUN otherwise: pc <= pc+4.
- hold_pc=1 only in RUN with stall_if & ~take.
- Arithmetic: pc4 = pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
- Latency: a redirect is visible on pc one edge after take; the first valid fetch at the target is REDIRECT_BUBBLES cycles later.

Optional Feature:
- Macro NPC_REDIRECT_STATS_EN.
- Defined:
  - redirect_cnt increments on every edge with take.
  - stall_cnt increments on every edge with hold_pc.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: both ports remain and are tied to 0; no counter flops are synthesized.

Test Plan:
- Reset, RESET_PC=32'h0, BOOT_CYCLES=1: release reset -> cycle 0 pc=0 with fetch_valid=0; next cycle pc=0 with fetch_valid=1; following edges pc=4, 8, 12.
- RUN at pc=0x10, stall_if=1 for 2 cycles -> pc stays 0x10, hold_pc=1 both cycles, no flush; then pc=0x14.
- RUN at pc=0x20, ex_valid=1, npc_op=1, npc_change=0x100, REDIRECT_BUBBLES=1 -> flush_ifid=flush_idex=1 that cycle; pc=0x100 with fetch_valid=0 for one cycle; then fetch_valid=1 and pc advances to 0x104.
- Same cycle: stall_if=1 and a take to 0x40 -> pc=0x40, hold_pc=0, flushes asserted.
- Take with npc_change=0x102 -> pc=0x100, misalign_err=1, still 1 after 10 cycles; clears only on reset.
- npc_op=1 during BOOT or with ex_valid=0 -> ignored, no flush. pc=0xFFFF_FFFC in RUN -> pc4=0 and next pc=0. With NPC_REDIRECT_STATS_EN: 3 takes and 2 stall cycles -> redirect_cnt=3, stall_cnt=2.

Source files
------------

// File: rtl/npc_redirect_ctrl.sv
// npc_redirect_ctrl
//   This block owns the fetch PC of the pipelined miniRV core and orders every
//   update to it. It chooses between three sources: sequential fetch (pc+4), a
//   taken redirect resolved in EX, and a load-use stall from the hazard unit.
//   It also drives the IF/ID and ID/EX flush strobes. After reset and after each
//   redirect it inserts fetch bubbles, which cover the read latency of the
//   synchronous instruction ROM.
//
// Optional feature (compile-time macro):
//   NPC_REDIRECT_STATS_EN : when defined, redirect_cnt and stall_cnt become
//                           saturating 32-bit counters. When undefined, both
//                           ports are tied to zero and no counter flops exist.
//
// Parameters:
//   RESET_PC          PC value loaded on reset.
//   BOOT_CYCLES       cycles that fetch_valid stays low after reset (1..15).
//   REDIRECT_BUBBLES  cycles that fetch_valid stays low after a taken redirect (0..15).
//
// Ports:
//   cpu_clk, cpu_rst  clock and synchronous active-high reset.
//   stall_if          load-use stall request (holds PC).
//   ex_valid, npc_op  EX holds a real instruction / that instruction redirects.
//   npc_change        redirect target.
//   pc, pc4           current fetch PC (registered) and pc+4.
//   fetch_valid       the instruction fetched at pc may enter IF/ID.
//   hold_pc           PC is held this cycle because of a stall.
//   flush_ifid/idex   flush the pipeline registers at the next edge.
//   misalign_err      sticky flag: a taken target had nonzero low bits.
//   redirect_cnt      count of taken redirects (optional feature).
//   stall_cnt         count of stall cycles (optional feature).
module npc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES      = 1,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        stall_if,
  input  logic        ex_valid,
  input  logic        npc_op,
  input  logic [31:0] npc_change,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_valid,
  output logic        hold_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign_err,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] RB_LOAD   = (REDIRECT_BUBBLES == 0) ? 4'd0
                                                             : 4'(REDIRECT_BUBBLES - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_misalign;
  logic        w_take;
  logic [31:0] w_target;

  assign w_target = {npc_change[31:2], 2'b00};

  // Reset gates the take, so a redirect that arrives during reset is dropped.
  assign w_take = ~cpu_rst & ex_valid & npc_op & (r_state != ST_BOOT);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_cnt      <= BOOT_LOAD;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_misalign <= r_misalign | (w_take & (npc_change[1:0] != 2'b00));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    fetch_valid = 1'b0;
    hold_pc     = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;

    if (!cpu_rst) begin
      flush_ifid = w_take;
      flush_idex = w_take;

      case (r_state)
        ST_BOOT: begin
          if (r_cnt == 4'd0) w_state_nxt = ST_RUN;
          else               w_cnt_nxt   = r_cnt - 4'd1;
        end
        ST_RUN: begin
          fetch_valid = 1'b1;
          if (!w_take && stall_if) begin
            hold_pc = 1'b1;
          end else if (!w_take) begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
        ST_FLUSH: begin
          if (!w_take) begin
            if (r_cnt == 4'd0) w_state_nxt = ST_RUN;
            else               w_cnt_nxt   = r_cnt - 4'd1;
          end
        end
        default: w_state_nxt = ST_BOOT;
      endcase

      // A take wins over both stall and sequential fetch in every state where
      // it is possible. In FLUSH it also reloads the target and restarts the
      // bubble count.
      if (w_take) begin
        w_pc_nxt    = w_target;
        w_cnt_nxt   = RB_LOAD;
        w_state_nxt = (REDIRECT_BUBBLES == 0) ? ST_RUN : ST_FLUSH;
      end
    end
  end

  assign pc           = r_pc;
  assign pc4          = r_pc + 32'd4;
  assign misalign_err = r_misalign;

`ifdef NPC_REDIRECT_STATS_EN
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_take && (r_redirect_cnt != '1)) r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (hold_pc && (r_stall_cnt != '1))   r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign stall_cnt    = r_stall_cnt;
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_npc_redirect_ctrl.sv
module tb_npc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        ex_valid;
  logic        npc_op;
  logic [31:0] npc_change;
  logic [31:0] pc, pc4;
  logic        fetch_valid, hold_pc, flush_ifid, flush_idex, misalign_err;
  logic [31:0] redirect_cnt, stall_cnt;

  npc_redirect_ctrl #(
    .RESET_PC        (32'h0000_0000),
    .BOOT_CYCLES     (1),
    .REDIRECT_BUBBLES(1)
  ) u_dut (
    .cpu_clk     (clk),
    .cpu_rst     (rst),
    .stall_if    (stall_if),
    .ex_valid    (ex_valid),
    .npc_op      (npc_op),
    .npc_change  (npc_change),
    .pc          (pc),
    .pc4         (pc4),
    .fetch_valid (fetch_valid),
    .hold_pc     (hold_pc),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .misalign_err(misalign_err),
    .redirect_cnt(redirect_cnt),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        fv;
    logic        hold;
    logic        fl;
    logic        mis;
    logic        chk_cnt;
    logic [31:0] rc;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef NPC_REDIRECT_STATS_EN
  localparam logic [31:0] EXP_RC = 32'd4;
  localparam logic [31:0] EXP_SC = 32'd2;
`else
  localparam logic [31:0] EXP_RC = 32'd0;
  localparam logic [31:0] EXP_SC = 32'd0;
`endif

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, tag, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc",          e.tag, pc,                  e.pc);
        chk("pc4",         e.tag, pc4,                 e.pc + 32'd4);
        chk("fetch_valid", e.tag, {31'd0, fetch_valid}, {31'd0, e.fv});
        chk("hold_pc",     e.tag, {31'd0, hold_pc},     {31'd0, e.hold});
        chk("flush_ifid",  e.tag, {31'd0, flush_ifid},  {31'd0, e.fl});
        chk("flush_idex",  e.tag, {31'd0, flush_idex},  {31'd0, e.fl});
        chk("misalign",    e.tag, {31'd0, misalign_err}, {31'd0, e.mis});
        if (e.chk_cnt) begin
          chk("redirect_cnt", e.tag, redirect_cnt, e.rc);
          chk("stall_cnt",    e.tag, stall_cnt,    e.sc);
        end
      end
    end
  end

  int tag = 0;

  // One cycle of stimulus: drive the inputs just after the edge, then queue the
  // hand-computed outputs for that cycle.
  task automatic cyc(input logic r, input logic st, input logic ev, input logic op,
                     input logic [31:0] tgt, input logic [31:0] e_pc, input logic e_fv,
                     input logic e_hold, input logic e_fl, input logic e_mis,
                     input logic e_cc = 1'b0, input logic [31:0] e_rc = '0,
                     input logic [31:0] e_sc = '0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_if = st; ex_valid = ev; npc_op = op; npc_change = tgt;
    e.tag = tag; e.pc = e_pc; e.fv = e_fv; e.hold = e_hold; e.fl = e_fl;
    e.mis = e_mis; e.chk_cnt = e_cc; e.rc = e_rc; e.sc = e_sc;
    q.push_back(e);
    tag++;
  endtask

  initial begin
    rst = 1'b1; stall_if = 1'b0; ex_valid = 1'b0; npc_op = 1'b0; npc_change = '0;
    repeat (2) @(posedge clk);
    // In reset with every request active: all combinational outputs are forced to 0.
    cyc(1, 1, 1, 1, 32'h200, 32'h0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    // BOOT: the take is ignored.
    cyc(0, 0, 1, 1, 32'h200, 32'h0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h4, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h8, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'hC, 1, 0, 0, 0);
    // Stall for two cycles at 0x10.
    cyc(0, 1, 0, 0, 32'h0,   32'h10, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 32'h0,   32'h10, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h10, 1, 0, 0, 0);
    // npc_op with ex_valid=0 is ignored.
    cyc(0, 0, 0, 1, 32'h300, 32'h14, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h18, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h1C, 1, 0, 0, 0);
    // Take to 0x100 from 0x20, followed by one bubble (stall ignored in FLUSH).
    cyc(0, 0, 1, 1, 32'h100, 32'h20,  1, 0, 1, 0);
    cyc(0, 1, 0, 0, 32'h0,   32'h100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h100, 1, 0, 0, 0);
    // Stall together with a take: the take wins.
    cyc(0, 1, 1, 1, 32'h40,  32'h104, 1, 0, 1, 0);
    // Take during FLUSH to the misaligned address 0x102.
    cyc(0, 0, 1, 1, 32'h102, 32'h40,  0, 0, 1, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h100, 0, 0, 0, 1);
    for (int k = 0; k <= 10; k++)
      cyc(0, 0, 0, 0, 32'h0, 32'h100 + 32'(4 * k), 1, 0, 0, 1);
    // Redirect to the top of the address space, then wrap around.
    cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h12C, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1, 1, EXP_RC, EXP_SC);
    // Reset in mid-operation with a take pending: outputs forced, the take is dropped.
    cyc(1, 1, 1, 1, 32'h500, 32'h4, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    cyc(0, 0, 0, 0, 32'h0,   32'h0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,   32'h4, 1, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
